ahb_slave_mux: RTL and testbench

- Data-phase response multiplexor that sits directly downstream of ahb_decoder and consumes its multi_sel_out encoding.
- Routes the selected slave's HRDATA/HREADY/HRESP back to the master.
- Contains the bus default slave, which gives a two-cycle ERROR for unmapped transfers.
- Contains a slave-hang watchdog that aborts a stalled data phase with ERROR.
- Its ready output drives the decoder's multi_ready_in and the master's HREADY.

---
 rtl/ahb_pkg.sv | 40 ++++
 rtl/ahb_slave_mux_if.sv | 32 +++
 rtl/ahb_default_slave.sv | 102 ++++++++++
 rtl/ahb_slave_mux.sv | 160 ++++++++++++++++
 tb/tb_ahb_slave_mux.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB encodings used by ahb_decoder and ahb_slave_mux:
//   - HTRANS transfer types
//   - HRESP values
//   - data-phase select encoding (the decoder's multi_sel_out)
//   - response-mux FSM states
// ---------------------------------------------------------------------------
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Select encoding: 0 = nothing, 1 = default slave, k+2 = slave k.
    localparam int SEL_NONE       = 0;
    localparam int SEL_DEFAULT    = 1;
    localparam int SEL_SLAVE_BASE = 2;

    // PASS  : normal pass-through (also the first cycle of a default-slave ERROR)
    // ERR2  : second ERROR cycle, shared by default slave and watchdog
    // TERR1 : first ERROR cycle of a watchdog abort
    typedef enum logic [1:0] {
        ST_PASS  = 2'd0,
        ST_ERR2  = 2'd1,
        ST_TERR1 = 2'd2
    } mux_state_e;

    // A transfer that actually needs a data phase (NONSEQ or SEQ).
    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_slave_mux_if.sv
// ---------------------------------------------------------------------------
// ahb_slave_mux_if
// Bus-side signals of the AHB data-phase response mux.
//   slave  modport : the mux's view (consumes select/slave responses,
//                    drives the master-facing HRDATA/HREADY/HRESP)
//   master modport : the surrounding fabric's view (drives inputs,
//                    observes the muxed response)
// ---------------------------------------------------------------------------
interface ahb_slave_mux_if #(
    parameter int SLAVE_DEVICES  = 2,
    parameter int AHB_DATA_WIDTH = 32,
    parameter int SEL_WIDTH      = $clog2(SLAVE_DEVICES) + 1
);
    logic [1:0]                              ahb_htrans_in;
    logic [SEL_WIDTH-1:0]                    multi_sel_in;
    logic [SLAVE_DEVICES*AHB_DATA_WIDTH-1:0] slave_rdata_in;
    logic [SLAVE_DEVICES-1:0]                slave_ready_in;
    logic [SLAVE_DEVICES-1:0]                slave_resp_in;
    logic [AHB_DATA_WIDTH-1:0]               ahb_rdata_out;
    logic                                    ahb_ready_out;
    logic                                    ahb_resp_out;

    modport slave (
        input  ahb_htrans_in, multi_sel_in, slave_rdata_in, slave_ready_in, slave_resp_in,
        output ahb_rdata_out, ahb_ready_out, ahb_resp_out
    );

    modport master (
        output ahb_htrans_in, multi_sel_in, slave_rdata_in, slave_ready_in, slave_resp_in,
        input  ahb_rdata_out, ahb_ready_out, ahb_resp_out
    );
endinterface

// File: rtl/ahb_default_slave.sv
// ---------------------------------------------------------------------------
// ahb_default_slave
// Bus default slave plus the response-mux state machine.
//   - Captures whether the current data phase belongs to a real transfer
//     (NONSEQ/SEQ) each time HREADY is high.
//   - Produces the two-cycle ERROR for active transfers to the default slave
//     and sequences the watchdog abort (TERR1 -> ERR2).
// Ports:
//   ahb_clk_in, ahb_rstn_in : clock, async active-low reset
//   htrans_in               : master HTRANS (address phase)
//   ready_in                : final muxed HREADY (address-phase qualifier)
//   default_sel_in          : data phase is addressed to the default slave
//   timeout_in              : watchdog fires this cycle
//   state_out               : current FSM state
//   dphase_active_out       : current data phase is a real transfer
//   owned_out               : this block, not a slave, supplies the response
//   ready_out / resp_out    : response when owned_out=1
// ---------------------------------------------------------------------------
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       ahb_clk_in,
    input  logic       ahb_rstn_in,
    input  logic [1:0] htrans_in,
    input  logic       ready_in,
    input  logic       default_sel_in,
    input  logic       timeout_in,
    output mux_state_e state_out,
    output logic       dphase_active_out,
    output logic       owned_out,
    output logic       ready_out,
    output logic       resp_out
);

    mux_state_e state_q, state_d;
    logic       dphase_active_q, dphase_active_d;

    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            state_q         <= ST_PASS;
            dphase_active_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            dphase_active_q <= dphase_active_d;
        end
    end

    // Next state. Kept apart from the output process: ready_in is derived
    // from owned_out/ready_out, so mixing the two would form a false loop.
    always_comb begin
        state_d         = state_q;
        dphase_active_d = dphase_active_q;
        if (ready_in)
            dphase_active_d = htrans_active(htrans_in);
        unique case (state_q)
            ST_PASS: begin
                if (default_sel_in && dphase_active_q)
                    state_d = ST_ERR2;
                else if (timeout_in)
                    state_d = ST_TERR1;
            end
            ST_TERR1: state_d = ST_ERR2;
            ST_ERR2:  state_d = ST_PASS;
            default:  state_d = ST_PASS;
        endcase
    end

    always_comb begin
        owned_out = 1'b0;
        ready_out = 1'b1;
        resp_out  = HRESP_OKAY;
        unique case (state_q)
            ST_PASS: begin
                if (default_sel_in) begin
                    owned_out = 1'b1;
                    // IDLE/BUSY to an unmapped address is a legal zero-wait OKAY.
                    if (dphase_active_q) begin
                        ready_out = 1'b0;
                        resp_out  = HRESP_ERROR;
                    end
                end
            end
            ST_TERR1: begin
                owned_out = 1'b1;
                ready_out = 1'b0;
                resp_out  = HRESP_ERROR;
            end
            ST_ERR2: begin
                owned_out = 1'b1;
                ready_out = 1'b1;
                resp_out  = HRESP_ERROR;
            end
            default: begin
                owned_out = 1'b1;
            end
        endcase
    end

    assign state_out         = state_q;
    assign dphase_active_out = dphase_active_q;

endmodule

// File: rtl/ahb_slave_mux.sv
// ---------------------------------------------------------------------------
// ahb_slave_mux
// AHB data-phase response multiplexor, downstream of ahb_decoder.
//   - Routes HRDATA/HREADY/HRESP of the selected slave to the master with
//     zero added latency.
//   - Hosts the bus default slave (two-cycle ERROR for unmapped transfers).
//   - Hang watchdog: a slave holding HREADY low for TIMEOUT_CYCLES cycles is
//     abandoned with a two-cycle ERROR; its late response is then ignored.
// Ports:
//   ahb_clk_in, ahb_rstn_in : clock, async active-low reset
//   bus (slave modport)     : HTRANS, multi_sel_in, per-slave responses in;
//                             muxed HRDATA/HREADY/HRESP out
//   timeout_clr_in          : synchronous clear of the sticky abort flag
//   timeout_flag_out        : sticky watchdog-abort flag
// ---------------------------------------------------------------------------
module ahb_slave_mux
    import ahb_pkg::*;
#(
    parameter int SLAVE_DEVICES  = 2,
    parameter int AHB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int SEL_WIDTH      = $clog2(SLAVE_DEVICES) + 1
) (
    input  logic              ahb_clk_in,
    input  logic              ahb_rstn_in,
    ahb_slave_mux_if.slave    bus,
    input  logic              timeout_clr_in,
    output logic              timeout_flag_out
);

    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LIMIT = WD_EN ? TIMEOUT_CYCLES - 1 : 0;

    // ---------------- select decode ----------------
    logic [SLAVE_DEVICES-1:0] sel_oh;
    logic                     slave_hit;
    logic                     sel_none;
    logic                     default_sel;

    for (genvar k = 0; k < SLAVE_DEVICES; k++) begin : g_sel
        assign sel_oh[k] = (int'(bus.multi_sel_in) == SEL_SLAVE_BASE + k);
    end

    assign slave_hit   = |sel_oh;
    assign sel_none    = (int'(bus.multi_sel_in) == SEL_NONE);
    // Anything neither "none" nor a real slave (including out-of-range
    // encodings) is served by the default slave.
    assign default_sel = !sel_none && !slave_hit;

    // ---------------- one-hot AND-OR slave mux ----------------
    logic [AHB_DATA_WIDTH-1:0] mux_rdata;
    logic                      mux_ready;
    logic                      mux_resp;

    always_comb begin
        mux_rdata = '0;
        mux_ready = 1'b0;
        mux_resp  = 1'b0;
        for (int k = 0; k < SLAVE_DEVICES; k++) begin
            mux_rdata = mux_rdata |
                        (bus.slave_rdata_in[k*AHB_DATA_WIDTH +: AHB_DATA_WIDTH] &
                         {AHB_DATA_WIDTH{sel_oh[k]}});
            mux_ready = mux_ready | (bus.slave_ready_in[k] & sel_oh[k]);
            mux_resp  = mux_resp  | (bus.slave_resp_in[k]  & sel_oh[k]);
        end
    end

    // ---------------- default slave / FSM ----------------
    mux_state_e ds_state;
    logic       dphase_active;
    logic       ds_owned;
    logic       ds_ready;
    logic       ds_resp;
    logic       timeout_hit;
    logic       ready_c;
    logic       resp_c;
    logic [AHB_DATA_WIDTH-1:0] rdata_c;

    ahb_default_slave u_default_slave (
        .ahb_clk_in        (ahb_clk_in),
        .ahb_rstn_in       (ahb_rstn_in),
        .htrans_in         (bus.ahb_htrans_in),
        .ready_in          (ready_c),
        .default_sel_in    (default_sel),
        .timeout_in        (timeout_hit),
        .state_out         (ds_state),
        .dphase_active_out (dphase_active),
        .owned_out         (ds_owned),
        .ready_out         (ds_ready),
        .resp_out          (ds_resp)
    );

    // ---------------- output selection ----------------
    always_comb begin
        ready_c = 1'b1;
        resp_c  = HRESP_OKAY;
        rdata_c = '0;
        if (ds_owned) begin
            // ERROR states ignore the (possibly late) slave response.
            ready_c = ds_ready;
            resp_c  = ds_resp;
        end else if (slave_hit) begin
            ready_c = mux_ready;
            resp_c  = mux_resp;
            rdata_c = mux_rdata;
        end
        // Reset forces the idle response without waiting for a clock edge.
        if (!ahb_rstn_in) begin
            ready_c = 1'b1;
            resp_c  = HRESP_OKAY;
            rdata_c = '0;
        end
    end

    assign bus.ahb_ready_out = ready_c;
    assign bus.ahb_resp_out  = resp_c;
    assign bus.ahb_rdata_out = rdata_c;

    // ---------------- watchdog ----------------
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic [CNT_W-1:0]     wait_q, wait_d;
    logic [CNT_W-1:0]     wait_cur;
    logic                 stall;
    logic                 flag_q, flag_d;

    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            sel_q  <= '0;
            wait_q <= '0;
            flag_q <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            wait_q <= wait_d;
            flag_q <= flag_d;
        end
    end

    always_comb begin
        sel_d    = bus.multi_sel_in;
        // A select change starts a new wait, so the stale count is dropped.
        wait_cur = (bus.multi_sel_in != sel_q) ? '0 : wait_q;
        stall    = WD_EN && (ds_state == ST_PASS) && slave_hit &&
                   dphase_active && !mux_ready;
        // wait_cur counts stall cycles already seen; this cycle is the last
        // one allowed when it equals TIMEOUT_CYCLES-1.
        timeout_hit = stall && (wait_cur == CNT_W'(LIMIT));
        wait_d = '0;
        if (stall && !timeout_hit)
            wait_d = wait_cur + 1'b1;
        flag_d = flag_q;
        if (timeout_clr_in)
            flag_d = 1'b0;
        if (timeout_hit)
            flag_d = 1'b1;
    end

    assign timeout_flag_out = flag_q;

endmodule

// File: tb/tb_ahb_slave_mux.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_mux
// Directed bench for ahb_slave_mux with TIMEOUT_CYCLES=8, two 32-bit slaves.
// Inputs change 1ns after the rising edge; outputs are checked on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_ahb_slave_mux;
    import ahb_pkg::*;

    localparam int NS = 2;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk;
    logic rstn;
    logic clr;
    logic flag;

    int n_asrt = 0;
    int n_fail = 0;

    ahb_slave_mux_if #(.SLAVE_DEVICES(NS), .AHB_DATA_WIDTH(DW)) bus_if ();

    ahb_slave_mux #(
        .SLAVE_DEVICES  (NS),
        .AHB_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .ahb_clk_in       (clk),
        .ahb_rstn_in      (rstn),
        .bus              (bus_if.slave),
        .timeout_clr_in   (clr),
        .timeout_flag_out (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic rdy, input logic rsp);
        chk({tag, ".ready"}, 32'(bus_if.ahb_ready_out), 32'(rdy));
        chk({tag, ".resp"},  32'(bus_if.ahb_resp_out),  32'(rsp));
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Address phase NONSEQ, then a data phase to slave 1 that never readies.
    // Returns at the falling edge of the TERR1 cycle.
    task automatic stall_abort(input string tag, input bit clr_on_hit);
        bus_if.ahb_htrans_in  = HTRANS_NONSEQ;
        bus_if.multi_sel_in   = 2'd0;
        bus_if.slave_ready_in = 2'b11;
        bus_if.slave_resp_in  = 2'b00;
        @(negedge clk);
        chk_bus({tag, ".aph"}, 1'b1, 1'b0);
        nxt();
        bus_if.ahb_htrans_in  = HTRANS_IDLE;
        bus_if.multi_sel_in   = 2'd3;
        bus_if.slave_ready_in = 2'b01;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            chk_bus($sformatf("%s.wait%0d", tag, i), 1'b0, 1'b0);
            if (clr_on_hit && i == TO - 1)
                clr = 1'b1;
            nxt();
            clr = 1'b0;
        end
        @(negedge clk);
        chk_bus({tag, ".terr1"}, 1'b0, 1'b1);
    endtask

    initial begin
        rstn                  = 1'b0;
        clr                   = 1'b0;
        bus_if.ahb_htrans_in  = HTRANS_IDLE;
        bus_if.multi_sel_in   = 2'd0;
        bus_if.slave_rdata_in = {32'hDEAD_BEEF, 32'hA5A5_0001};
        bus_if.slave_ready_in = 2'b11;
        bus_if.slave_resp_in  = 2'b00;

        // ---- reset state ----
        #1;
        chk_bus("rst", 1'b1, 1'b0);
        chk("rst.rdata", bus_if.ahb_rdata_out, 32'h0);
        chk("rst.flag", 32'(flag), 32'h0);
        nxt();
        rstn = 1'b1;

        // ---- 1: idle bus ----
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_bus($sformatf("idle%0d", i), 1'b1, 1'b0);
            chk($sformatf("idle%0d.rdata", i), bus_if.ahb_rdata_out, 32'h0);
            chk($sformatf("idle%0d.flag", i), 32'(flag), 32'h0);
            nxt();
        end

        // ---- 2: slave pass-through ----
        bus_if.ahb_htrans_in = HTRANS_NONSEQ;
        nxt();
        bus_if.multi_sel_in = 2'd2;
        @(negedge clk);
        chk_bus("s0", 1'b1, 1'b0);
        chk("s0.rdata", bus_if.ahb_rdata_out, 32'hA5A5_0001);
        nxt();
        bus_if.multi_sel_in  = 2'd3;
        bus_if.ahb_htrans_in = HTRANS_IDLE;
        @(negedge clk);
        chk_bus("s1", 1'b1, 1'b0);
        chk("s1.rdata", bus_if.ahb_rdata_out, 32'hDEAD_BEEF);
        nxt();

        // ---- 3: default slave, active transfer -> two-cycle ERROR ----
        bus_if.multi_sel_in  = 2'd0;
        bus_if.ahb_htrans_in = HTRANS_NONSEQ;
        nxt();
        bus_if.multi_sel_in  = 2'd1;
        bus_if.ahb_htrans_in = HTRANS_IDLE;
        @(negedge clk);
        chk_bus("def.err1", 1'b0, 1'b1);
        nxt();
        @(negedge clk);
        chk_bus("def.err2", 1'b1, 1'b1);
        chk("def.err2.rdata", bus_if.ahb_rdata_out, 32'h0);
        nxt();
        // IDLE was captured during ERR2: same select now gives zero-wait OKAY.
        @(negedge clk);
        chk_bus("def.idle", 1'b1, 1'b0);
        nxt();
        bus_if.multi_sel_in = 2'd0;
        @(negedge clk);
        chk_bus("def.pass", 1'b1, 1'b0);
        nxt();

        // ---- 4: slave-originated ERROR passes through ----
        bus_if.ahb_htrans_in = HTRANS_NONSEQ;
        nxt();
        bus_if.ahb_htrans_in  = HTRANS_IDLE;
        bus_if.multi_sel_in   = 2'd2;
        bus_if.slave_ready_in = 2'b10;
        bus_if.slave_resp_in  = 2'b01;
        @(negedge clk);
        chk_bus("serr1", 1'b0, 1'b1);
        nxt();
        bus_if.slave_ready_in = 2'b11;
        @(negedge clk);
        chk_bus("serr2", 1'b1, 1'b1);
        chk("serr2.rdata", bus_if.ahb_rdata_out, 32'hA5A5_0001);
        nxt();
        bus_if.multi_sel_in  = 2'd0;
        bus_if.slave_resp_in = 2'b00;
        @(negedge clk);
        chk_bus("serr.done", 1'b1, 1'b0);
        nxt();

        // ---- 5: watchdog abort and sticky flag ----
        stall_abort("wd1", 1'b0);
        chk("wd1.terr1.flag", 32'(flag), 32'h1);
        nxt();
        @(negedge clk);
        chk_bus("wd1.err2", 1'b1, 1'b1);
        chk("wd1.err2.rdata", bus_if.ahb_rdata_out, 32'h0);
        nxt();
        bus_if.multi_sel_in   = 2'd0;
        bus_if.slave_ready_in = 2'b11;
        @(negedge clk);
        chk_bus("wd1.pass", 1'b1, 1'b0);
        nxt();
        @(negedge clk);
        chk("wd1.sticky", 32'(flag), 32'h1);
        nxt();

        // clear coinciding with a fresh abort: set wins
        stall_abort("wd2", 1'b1);
        chk("wd2.setwins", 32'(flag), 32'h1);
        nxt();
        @(negedge clk);
        chk_bus("wd2.err2", 1'b1, 1'b1);
        nxt();
        bus_if.multi_sel_in   = 2'd0;
        bus_if.slave_ready_in = 2'b11;
        clr = 1'b1;
        nxt();
        clr = 1'b0;
        @(negedge clk);
        chk("wd2.cleared", 32'(flag), 32'h0);
        nxt();

        // ---- 6: reset during TERR1 ----
        stall_abort("wd3", 1'b0);
        rstn = 1'b0;
        #1;
        chk_bus("wd3.rst", 1'b1, 1'b0);
        chk("wd3.rst.rdata", bus_if.ahb_rdata_out, 32'h0);
        chk("wd3.rst.flag", 32'(flag), 32'h0);
        nxt();
        rstn = 1'b1;
        nxt();
        stall_abort("wd4", 1'b0);
        nxt();
        @(negedge clk);
        chk_bus("wd4.err2", 1'b1, 1'b1);
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
